vga_timing_gen: RTL



---
 rtl/vga_timing_gen_pkg.sv | 31 +++
 rtl/vga_timing_gen_if.sv | 37 +++
 rtl/vga_axis_counter.sv | 68 ++++++
 rtl/vga_timing_gen.sv | 109 ++++++++++
 4 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared definitions for the VGA timing generator: the 2-bit raster phase
// encoding, default 640x480@60 timing constants and the axis-total helper.
package vga_timing_gen_pkg;

    // Phase of one raster axis: visible, front porch, sync pulse, back porch.
    typedef enum logic [1:0] {
        PH_ACT = 2'd0,
        PH_FP  = 2'd1,
        PH_SY  = 2'd2,
        PH_BP  = 2'd3
    } phase_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;
    localparam int DEF_CW       = 10;

    // Length of one full axis period (line or frame) in steps.
    function automatic int axis_total(input int act, input int fp, input int sy, input int bp);
        return act + fp + sy + bp;
    endfunction

    localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
    localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle of the VGA timing generator.
// Handshake: there is no valid/ready pair. PIX_EN is the only qualifier; a
// CLK edge with PIX_EN high is one pixel tick, and the generator samples
// RGB_IN on that tick for the (X,Y) it presented during the previous tick.
// With PIX_EN low nothing moves. H_PHASE/V_PHASE expose the FSM states.
interface vga_timing_gen_if #(
    parameter int CW = 10
);
    import vga_timing_gen_pkg::*;

    logic          PIX_EN;
    logic [2:0]    RGB_IN;
    logic [CW-1:0] X;
    logic [CW-1:0] Y;
    logic          ACTIVE;
    logic          FRAME_START;
    logic          HSYNC;
    logic          VSYNC;
    logic          R;
    logic          G;
    logic          B;
    phase_t        H_PHASE;
    phase_t        V_PHASE;

    // Pixel source / testbench side.
    modport master (
        output PIX_EN, RGB_IN,
        input  X, Y, ACTIVE, FRAME_START, HSYNC, VSYNC, R, G, B, H_PHASE, V_PHASE
    );

    // Timing generator side.
    modport slave (
        input  PIX_EN, RGB_IN,
        output X, Y, ACTIVE, FRAME_START, HSYNC, VSYNC, R, G, B, H_PHASE, V_PHASE
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: a position counter plus the ACT/FP/SY/BP phase FSM.
// The counter and the phase advance together on each step; wrap is high
// combinationally on the step that returns the count to zero.
module vga_axis_counter
    import vga_timing_gen_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FRONT  = DEF_H_FRONT,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BACK   = DEF_H_BACK,
    parameter int CW     = DEF_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          step,
    output logic [CW-1:0] count,
    output phase_t        phase,
    output logic          wrap
);

    localparam int TOTAL = axis_total(ACTIVE, FRONT, SYNC, BACK);

    // Last count value of each phase.
    localparam logic [CW-1:0] LAST_ACT = CW'(ACTIVE - 1);
    localparam logic [CW-1:0] LAST_FP  = CW'(ACTIVE + FRONT - 1);
    localparam logic [CW-1:0] LAST_SY  = CW'(ACTIVE + FRONT + SYNC - 1);
    localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);

    logic [CW-1:0] count_q, count_d;
    phase_t        phase_q, phase_d;

    // State register: reset restarts the axis at position 0, visible phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            phase_q <= PH_ACT;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

    // Next count and phase; phases change on the step leaving their last count.
    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        wrap    = 1'b0;
        if (step) begin
            if (count_q == LAST) begin
                count_d = '0;
                wrap    = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
            case (phase_q)
                PH_ACT:  if (count_q == LAST_ACT) phase_d = PH_FP;
                PH_FP:   if (count_q == LAST_FP)  phase_d = PH_SY;
                PH_SY:   if (count_q == LAST_SY)  phase_d = PH_BP;
                PH_BP:   if (count_q == LAST)     phase_d = PH_ACT;
                default: phase_d = PH_ACT;
            endcase
        end
    end

    assign count = count_q;
    assign phase = phase_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with registered HSYNC/VSYNC/R/G/B pins.
// Optional macro VGA_TEST_PATTERN_EN replaces RGB_IN with 8 vertical colour
// bars (bar index of X) while keeping latency and blanking identical.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FRONT  = DEF_H_FRONT,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BACK   = DEF_H_BACK,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FRONT  = DEF_V_FRONT,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BACK   = DEF_V_BACK,
    parameter logic SYNC_POL = 1'b0,
    parameter int   CW       = DEF_CW
) (
    input  logic           CLK,
    input  logic           RST_N,
    vga_timing_gen_if.slave bus
);

    localparam logic [CW-1:0] H_VIS = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS = CW'(V_ACTIVE);

    logic [CW-1:0] h, v;
    phase_t        h_phase, v_phase;
    logic          h_wrap, v_wrap, v_step;
    logic          active;
    logic [2:0]    pix;

    logic          hsync_q, vsync_q, fs_q;
    logic [2:0]    rgb_q;

    // The vertical axis moves one line on the tick that ends a line.
    assign v_step = bus.PIX_EN & h_wrap;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK),
        .CW     (CW)
    ) u_h (
        .clk   (CLK),
        .rst_n (RST_N),
        .step  (bus.PIX_EN),
        .count (h),
        .phase (h_phase),
        .wrap  (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK),
        .CW     (CW)
    ) u_v (
        .clk   (CLK),
        .rst_n (RST_N),
        .step  (v_step),
        .count (v),
        .phase (v_phase),
        .wrap  (v_wrap)
    );

    assign active = (h < H_VIS) && (v < V_VIS);

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [CW-1:0] BAR_W = CW'(H_ACTIVE / 8);
    logic [CW-1:0] bar_idx;
    assign bar_idx = h / BAR_W;
    assign pix     = bar_idx[2:0];
`else
    assign pix = bus.RGB_IN;
`endif

    // Pin registers: sync from the pre-advance phase, colour gated by ACTIVE.
    // FRAME_START marks the tick that wraps both axes; v_wrap implies PIX_EN.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            rgb_q   <= 3'b000;
            fs_q    <= 1'b0;
        end else begin
            fs_q <= v_wrap;
            if (bus.PIX_EN) begin
                hsync_q <= (h_phase == PH_SY) ? SYNC_POL : ~SYNC_POL;
                vsync_q <= (v_phase == PH_SY) ? SYNC_POL : ~SYNC_POL;
                rgb_q   <= active ? pix : 3'b000;
            end
        end
    end

    assign bus.X           = h;
    assign bus.Y           = v;
    assign bus.ACTIVE      = active;
    assign bus.FRAME_START = fs_q;
    assign bus.HSYNC       = hsync_q;
    assign bus.VSYNC       = vsync_q;
    assign bus.R           = rgb_q[2];
    assign bus.G           = rgb_q[1];
    assign bus.B           = rgb_q[0];
    assign bus.H_PHASE     = h_phase;
    assign bus.V_PHASE     = v_phase;

endmodule
